// File: rtl/poly_mult_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poly_mult_pkg - operation encoding shared by the poly_arithmetic multipliers
// Rev 1.0
// ----------------------------------------------------------------------------
package poly_mult_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_UMUL  = 2'b00;
  localparam mode_t MODE_SMUL  = 2'b01;
  localparam mode_t MODE_CLMUL = 2'b10;

  function automatic logic is_signed_mode(input mode_t m);
    return (m == MODE_SMUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clmul_comb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clmul_comb - combinational carry-less (GF(2)[x]) product of two W-bit operands
// Rev 1.0
// ----------------------------------------------------------------------------
module clmul_comb
  import poly_mult_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-2:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) begin
        p = p ^ ({{(W-1){1'b0}}, a} << i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_pipe - pipelined WxW unsigned/signed/carry-less multiplier with stall
// Rev 1.0
// ----------------------------------------------------------------------------
module mult_pipe
  import poly_mult_pkg::*;
#(
  parameter int W     = 64,
  parameter int LAT   = 6,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  mode_t              mode,
  input  logic [TAG_W-1:0]   tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     p,
  output logic [TAG_W-1:0]   out_tag
);

  logic                  adv;
  logic [W:0]            a_ext;
  logic [W:0]            b_ext;
  logic signed [2*W+1:0] sprod;
  logic [1:0]            sprod_hi_unused;
  logic [2*W-2:0]        clprod;
  logic [2*W-1:0]        prod;

  logic [LAT-1:0]        vld_q;
  logic [TAG_W-1:0]      tag_q  [LAT];
  logic [2*W-1:0]        data_q [LAT];

  // One (W+1)-bit signed multiplier serves both modes: the extension bit
  // copies the MSB only for signed operations, otherwise it is zero.
  assign a_ext = {is_signed_mode(mode) & a[W-1], a};
  assign b_ext = {is_signed_mode(mode) & b[W-1], b};
  assign sprod = $signed(a_ext) * $signed(b_ext);
  assign sprod_hi_unused = sprod[2*W+1:2*W];

  clmul_comb #(.W(W)) u_clmul (
    .a (a),
    .b (b),
    .p (clprod)
  );

  assign prod = (mode == MODE_CLMUL) ? {1'b0, clprod} : sprod[2*W-1:0];

  assign adv      = !vld_q[LAT-1] || out_ready;
  assign in_ready = adv && !flush;

  // Product is formed at entry; remaining stages let synthesis retime it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0]  <= in_valid;
      tag_q[0]  <= tag;
      data_q[0] <= prod;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign p         = data_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mult_pipe - self-checking bench for mult_pipe at (64,6), (16,1), (32,3)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mult_pipe;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [2:0]   fl = '0;
  logic [2:0]   iv = '0;
  logic [2:0]   ordy = '1;
  logic [63:0]  a_s = '0;
  logic [63:0]  b_s = '0;
  logic [1:0]   mode_s = '0;
  logic [7:0]   tag_s = '0;

  logic         ir0, ir1, ir2;
  logic         ov0, ov1, ov2;
  logic [127:0] p0;
  logic [31:0]  p1;
  logic [63:0]  p2;
  logic [7:0]   t0, t1, t2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [127:0] q_p [$];
  logic [7:0]   q_t [$];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_p;
  logic [7:0]   prev_t;

  always #5 clk = ~clk;

  mult_pipe #(.W(64), .LAT(6), .TAG_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
    .a(a_s), .b(b_s), .mode(mode_s), .tag(tag_s),
    .out_valid(ov0), .out_ready(ordy[0]), .p(p0), .out_tag(t0));

  mult_pipe #(.W(16), .LAT(1), .TAG_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
    .a(a_s[15:0]), .b(b_s[15:0]), .mode(mode_s), .tag(tag_s),
    .out_valid(ov1), .out_ready(ordy[1]), .p(p1), .out_tag(t1));

  mult_pipe #(.W(32), .LAT(3), .TAG_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir2),
    .a(a_s[31:0]), .b(b_s[31:0]), .mode(mode_s), .tag(tag_s),
    .out_valid(ov2), .out_ready(ordy[2]), .p(p2), .out_tag(t2));

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference product from the arithmetic definition at operand width w.
  function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] m, input int w);
    logic [127:0] one = 128'd1;
    logic [127:0] mw, m2w, x, y, r;
    mw  = (one << w) - 1;
    m2w = (one << (2 * w)) - 1;
    x = {64'd0, a} & mw;
    y = {64'd0, b} & mw;
    r = '0;
    if (m == 2'b01) begin
      if (x[w-1]) x = x | ~mw;
      if (y[w-1]) y = y | ~mw;
      r = x * y;
    end else if (m == 2'b10) begin
      for (int i = 0; i < w; i++) if (y[i]) r = r ^ (x << i);
    end else begin
      r = x * y;
    end
    return r & m2w;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_8000_8000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic sample(input int k, output logic ov, output logic ir,
                        output logic [127:0] p, output logic [7:0] t);
    case (k)
      0:       begin ov = ov0; ir = ir0; p = p0;              t = t0; end
      1:       begin ov = ov1; ir = ir1; p = {96'd0, p1};     t = t1; end
      default: begin ov = ov2; ir = ir2; p = {64'd0, p2};     t = t2; end
    endcase
  endtask

  // One clock of handshake traffic against the scoreboard.
  task automatic step(input int k, input int w, input bit v, input logic [63:0] a,
                      input logic [63:0] b, input logic [1:0] m, input logic [7:0] t,
                      input bit r, output bit acc);
    logic ov, ir;
    logic [127:0] p;
    logic [7:0] tg;
    @(negedge clk);
    iv[k] = v; ordy[k] = r; a_s = a; b_s = b; mode_s = m; tag_s = t;
    #1;
    sample(k, ov, ir, p, tg);
    if (prev_stall) begin
      check_eq("hold_valid", {127'd0, ov}, 128'd1);
      check_eq("hold_p", p, prev_p);
      check_eq("hold_tag", {120'd0, tg}, {120'd0, prev_t});
    end
    check_eq("in_ready", {127'd0, ir}, {127'd0, (!ov || r)});
    if (ov && r) begin
      if (q_p.size() == 0) begin
        check_eq("spurious_out", {127'd0, ov}, 128'd0);
      end else begin
        check_eq("p", p, q_p.pop_front());
        check_eq("tag", {120'd0, tg}, {120'd0, q_t.pop_front()});
        n_out++;
      end
    end
    acc = v && ir;
    if (acc) begin
      q_p.push_back(ref_prod(a, b, m, w));
      q_t.push_back(t);
    end
    prev_stall = ov && !r;
    prev_p = p;
    prev_t = tg;
  endtask

  // Single isolated operation with exact latency check.
  task automatic send_one(input int k, input int lat, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] m, input logic [7:0] t, input logic [127:0] exp);
    logic ov, ir;
    logic [127:0] p;
    logic [7:0] tg;
    @(negedge clk);
    iv[k] = 1'b1; ordy[k] = 1'b1; a_s = a; b_s = b; mode_s = m; tag_s = t;
    #1;
    sample(k, ov, ir, p, tg);
    check_eq("send_ready", {127'd0, ir}, 128'd1);
    @(negedge clk);
    iv[k] = 1'b0;
    for (int i = 1; i < lat; i++) begin
      #1;
      sample(k, ov, ir, p, tg);
      check_eq("early_valid", {127'd0, ov}, 128'd0);
      @(negedge clk);
    end
    #1;
    sample(k, ov, ir, p, tg);
    check_eq("lat_valid", {127'd0, ov}, 128'd1);
    check_eq("lat_p", p, exp);
    check_eq("lat_tag", {120'd0, tg}, {120'd0, t});
    @(negedge clk);
    #1;
    sample(k, ov, ir, p, tg);
    check_eq("no_dup", {127'd0, ov}, 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ov, ir;
    logic [127:0] p;
    logic [7:0] tg;
    bit acc;
    int next;
    int w, lat;

    // Asynchronous reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      sample(k, ov, ir, p, tg);
      check_eq("rst_valid", {127'd0, ov}, 128'd0);
      check_eq("rst_p", p, 128'd0);
      check_eq("rst_tag", {120'd0, tg}, 128'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    sample(0, ov, ir, p, tg);
    check_eq("rst_ready", {127'd0, ir}, 128'd1);

    // Directed products on the 64-bit, 6-stage instance.
    send_one(0, 6, '1, 64'd2, 2'b00, 8'h11, 128'h1_FFFF_FFFF_FFFF_FFFE);
    send_one(0, 6, '1, '1, 2'b01, 8'h21, 128'd1);
    send_one(0, 6, '1, 64'd2, 2'b01, 8'h22, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    send_one(0, 6, 64'd3, 64'd3, 2'b10, 8'h31, 128'd5);
    send_one(0, 6, 64'h87, 64'h02, 2'b10, 8'h32, 128'h10E);
    send_one(0, 6, '1, '1, 2'b10, 8'h33, 128'h5555_5555_5555_5555_5555_5555_5555_5555);
    send_one(0, 6, '1, '1, 2'b11, 8'h41, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Backpressure: tags 0..9 back to back, consumer stalls cycles 8..11.
    n_out = 0;
    next = 0;
    for (int c = 0; c < 40; c++) begin
      step(0, 64, (next < 10), pick(), pick(), 2'($urandom_range(0, 3)), 8'(next),
           !(c >= 8 && c <= 11), acc);
      if (acc) next++;
    end
    check_eq("bp_count", 128'(n_out), 128'd10);
    check_eq("bp_left", 128'(q_p.size()), 128'd0);

    // Flush with three operations in flight and an offered input.
    for (int i = 0; i < 3; i++) step(0, 64, 1'b1, pick(), pick(), 2'b00, 8'(i), 1'b1, acc);
    @(negedge clk);
    fl[0] = 1'b1; iv[0] = 1'b1;
    #1;
    sample(0, ov, ir, p, tg);
    check_eq("flush_ready", {127'd0, ir}, 128'd0);
    @(negedge clk);
    fl[0] = 1'b0; iv[0] = 1'b0;
    q_p.delete(); q_t.delete(); prev_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      sample(0, ov, ir, p, tg);
      check_eq("flush_empty", {127'd0, ov}, 128'd0);
      @(negedge clk);
    end
    send_one(0, 6, 64'd7, 64'd9, 2'b00, 8'h55, 128'd63);

    // Reset while the pipe is full and stalled.
    for (int i = 0; i < 8; i++) step(0, 64, 1'b1, pick(), pick(), 2'b01, 8'(i + 100), 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sample(0, ov, ir, p, tg);
    check_eq("midrst_valid", {127'd0, ov}, 128'd0);
    check_eq("midrst_p", p, 128'd0);
    check_eq("midrst_tag", {120'd0, tg}, 128'd0);
    iv[0] = 1'b0; ordy[0] = 1'b1;
    q_p.delete(); q_t.delete(); prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic on every parameter set.
    for (int k = 0; k < 3; k++) begin
      w   = (k == 0) ? 64 : (k == 1) ? 16 : 32;
      lat = (k == 0) ? 6 : (k == 1) ? 1 : 3;
      send_one(k, lat, 64'h1234_5678_9ABC_DEF0, 64'h3, 2'b00, 8'hA5,
               ref_prod(64'h1234_5678_9ABC_DEF0, 64'h3, 2'b00, w));
      for (int c = 0; c < 300; c++)
        step(k, w, ($urandom_range(0, 3) != 0), pick(), pick(), 2'($urandom_range(0, 3)),
             8'($urandom), ($urandom_range(0, 3) != 0), acc);
      for (int c = 0; c < 40 && q_p.size() != 0; c++)
        step(k, w, 1'b0, '0, '0, 2'b00, 8'd0, 1'b1, acc);
      check_eq("drain_empty", 128'(q_p.size()), 128'd0);
      iv[k] = 1'b0;
      q_p.delete(); q_t.delete(); prev_stall = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
